// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a four-phase req/ack crossing.
// Optional stuck-handshake abort: define CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] send_data,
    input  logic              ack_async,
    output logic              ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   r_req;
    logic                   w_req_nxt;
    logic [DATA_W-1:0]      r_data;
    logic [DATA_W-1:0]      w_data_nxt;
    logic                   r_done;
    logic                   w_done_nxt;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("cdc_handshake_tx: illegal parameter value");
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_expired;

    // Abort once the handshake has waited its full cycle allowance.
    assign w_expired = (r_cnt == CNT_LAST);
`endif

    // Ack synchronizer; only the last stage is ever consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
    assign ready   = (r_state == IDLE) && !w_ack_s;

    // Next-state and next-output decode for the handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (send && ready) begin
                    w_data_nxt  = send_data;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = REQ;
`ifdef CDC_TX_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            REQ: begin
`ifdef CDC_TX_TIMEOUT_EN
                w_cnt_nxt = r_cnt + 1'b1;
`endif
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = RELEASE;
`ifdef CDC_TX_TIMEOUT_EN
                    w_cnt_nxt   = '0;
                end else if (w_expired) begin
                    w_req_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
`endif
                end
            end
            RELEASE: begin
`ifdef CDC_TX_TIMEOUT_EN
                w_cnt_nxt = r_cnt + 1'b1;
`endif
                if (!w_ack_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
`ifdef CDC_TX_TIMEOUT_EN
                end else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    // Wait counter and timeout pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign req_out  = r_req;
    assign data_out = r_data;
    assign done     = r_done;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: scoreboard bench for cdc_handshake_tx.
// Directed protocol cases followed by randomized transfers.
module tb_cdc_handshake_tx;

    localparam int DW   = 8;
    localparam int SYNC = 3;
    localparam int TO   = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          send;
    logic [DW-1:0] send_data;
    logic          ack_async;
    logic          ready;
    logic          req_out;
    logic [DW-1:0] data_out;
    logic          done;
    logic          timeout;

    logic          ack_man;
    logic          ack_resp;
    logic          resp_en;
    int            rdly;

    int            n_chk;
    int            n_fail;
    int            n_done;
    int            n_to;
    int            cyc;
    int            ack_edge;
    logic          prev_req;
    logic [DW-1:0] exp_q[$];

    cdc_handshake_tx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .send      (send),
        .send_data (send_data),
        .ack_async (ack_async),
        .ready     (ready),
        .req_out   (req_out),
        .data_out  (data_out),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ack_async = resp_en ? ack_resp : ack_man;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst     = 1'b1;
        send    = 1'b0;
        ack_man = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_req", req_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Remember the edge just before each ack transition.
    initial begin
        forever begin
            @(ack_async);
            ack_edge = cyc;
        end
    end

    // Destination model: ack follows req after a random delay.
    initial begin
        ack_resp = 1'b0;
        rdly     = 0;
        forever begin
            @(posedge clk);
            #3;
            if (!resp_en) begin
                ack_resp = 1'b0;
                rdly     = $urandom_range(0, 4);
            end else if (req_out != ack_resp) begin
                if (rdly == 0) begin
                    ack_resp = req_out;
                    rdly     = $urandom_range(0, 4);
                end else begin
                    rdly--;
                end
            end
        end
    end

    // Monitor: pops expected payloads on done/timeout and checks latency.
    initial begin
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (done && timeout) begin
                chk("done_and_timeout", {done, timeout}, 2'b10);
            end
            if (!rst) begin
                if (req_out && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        chk("req_unexpected", req_out, 0);
                    end else begin
                        chk("req_data", data_out, exp_q[0]);
                    end
                end
                if (prev_req && !req_out && !timeout) begin
                    chk("req_fall_lat", cyc, ack_edge + SYNC + 1);
                end
                if (done) begin
                    n_done++;
                    chk("done_lat", cyc, ack_edge + SYNC + 1);
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", done, 0);
                    end else begin
                        chk("done_data", data_out, exp_q.pop_front());
                    end
                end
                if (timeout) begin
                    n_to++;
                    if (exp_q.size() == 0) begin
                        chk("timeout_unexpected", timeout, 0);
                    end else begin
                        chk("timeout_data", data_out, exp_q.pop_front());
                    end
                end
            end
            prev_req = req_out;
        end
    end

    initial begin
        int base;
        int k;
        logic seen;
        logic held;
        logic [DW-1:0] d;

        n_chk     = 0;
        n_fail    = 0;
        n_done    = 0;
        n_to      = 0;
        cyc       = 0;
        ack_edge  = -100;
        rst       = 1'b1;
        send      = 1'b0;
        send_data = '0;
        ack_man   = 1'b0;
        resp_en   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("init_req", req_out, 0);
        chk("init_data", data_out, 0);
        chk("init_done", done, 0);
        chk("init_timeout", timeout, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", ready, 1);

        // Basic transfer with a busy send in the middle.
        send      = 1'b1;
        send_data = 8'hA5;
        exp_q.push_back(8'hA5);
        base = n_done;
        tick();
        chk("b_req_rise", req_out, 1);
        chk("b_data", data_out, 8'hA5);
        send = 1'b0;
        tick();
        send      = 1'b1;
        send_data = 8'h3C;
        tick();
        chk("busy_data", data_out, 8'hA5);
        chk("busy_ready", ready, 0);
        send = 1'b0;
        repeat (2) tick();
        ack_man = 1'b1;
        repeat (3) tick();
        chk("b_req_hold", req_out, 1);
        tick();
        chk("b_req_fall", req_out, 0);
        repeat (3) tick();
        ack_man = 1'b0;
        repeat (3) tick();
        chk("b_done_early", done, 0);
        tick();
        chk("b_done", done, 1);
        chk("b_ready", ready, 1);
        chk("b_data_hold", data_out, 8'hA5);
        tick();
        chk("b_done_pulse", done, 0);
        chk("b_one_done", n_done - base, 1);

        // Stale ack while idle.
        do_reset();
        ack_man = 1'b1;
        repeat (4) tick();
        chk("stale_ready", ready, 0);
        send      = 1'b1;
        send_data = 8'h11;
        tick();
        send = 1'b0;
        chk("stale_req", req_out, 0);
        chk("stale_data", data_out, 0);
        tick();
        ack_man = 1'b0;
        repeat (SYNC - 1) tick();
        chk("stale_ready_hold", ready, 0);
        tick();
        chk("stale_ready_back", ready, 1);

        // Reset during REQ.
        base      = n_done;
        send      = 1'b1;
        send_data = 8'h5A;
        exp_q.push_back(8'h5A);
        tick();
        send = 1'b0;
        chk("mr_req", req_out, 1);
        repeat (2) tick();
        do_reset();
        chk("mr_ready", ready, 1);

        // Reset during RELEASE.
        send      = 1'b1;
        send_data = 8'hC3;
        exp_q.push_back(8'hC3);
        tick();
        send    = 1'b0;
        ack_man = 1'b1;
        repeat (SYNC + 1) tick();
        chk("rel_req", req_out, 0);
        chk("rel_ready", ready, 0);
        do_reset();
        repeat (SYNC + 3) tick();
        chk("mr_no_done", n_done - base, 0);
        chk("mr_no_to", n_to, 0);

        // Back-to-back transfers with send held high.
        resp_en = 1'b1;
        base    = n_done;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        send      = 1'b1;
        send_data = 8'h01;
        k         = 0;
        seen      = 1'b0;
        for (int i = 0; i < 400 && k < 3; i++) begin
            tick();
            if (req_out && !seen) begin
                k++;
                send_data = DW'(k + 1);
                if (k == 3) send = 1'b0;
            end
            seen = req_out;
        end
        send = 1'b0;
        chk("b2b_accepts", k, 3);
        for (int i = 0; i < 200 && n_done < base + 3; i++) tick();
        chk("b2b_done", n_done - base, 3);

        // Randomized transfers with ignored sends while busy.
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            chk("rnd_ready", ready, 1);
            d         = DW'($urandom);
            send      = 1'b1;
            send_data = d;
            exp_q.push_back(d);
            base = n_done;
            tick();
            send = 1'b0;
            k    = 0;
            while (n_done == base && k < 200) begin
                if (req_out && $urandom_range(0, 3) == 0) begin
                    send      = 1'b1;
                    send_data = ~d;
                    tick();
                    send = 1'b0;
                end else begin
                    tick();
                end
                k++;
            end
            chk("rnd_done", n_done - base, 1);
        end
        resp_en = 1'b0;
        tick();

`ifdef CDC_TX_TIMEOUT_EN
        base      = n_to;
        send      = 1'b1;
        send_data = 8'h77;
        exp_q.push_back(8'h77);
        tick();
        send = 1'b0;
        repeat (TO - 1) tick();
        chk("to_early", timeout, 0);
        chk("to_req_hold", req_out, 1);
        tick();
        chk("to_pulse", timeout, 1);
        chk("to_req", req_out, 0);
        chk("to_ready", ready, 1);
        chk("to_no_done", done, 0);
        tick();
        chk("to_one_cycle", timeout, 0);
        chk("to_count", n_to - base, 1);
`else
        send      = 1'b1;
        send_data = 8'h77;
        exp_q.push_back(8'h77);
        tick();
        send = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!req_out || timeout) held = 1'b0;
        end
        chk("no_to_hold", held, 1);
        do_reset();
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
